// File: rtl/axi4_burst_pkg.sv
// axi4_burst_pkg: shared AXI response/burst codes and slave FSM states
package axi4_burst_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
endpackage

// File: rtl/axi4_burst_slave_mem_if.sv
// axi4_burst_slave_mem_if: AXI4 bus bundle between a burst master and the slave memory
interface axi4_burst_slave_mem_if #(
  parameter int ID_W = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_burst_mem_ram.sv
// axi4_burst_mem_ram: word RAM with one byte-enabled write port and one asynchronous read port
module axi4_burst_mem_ram #(
  parameter int DW = 32,
  parameter int D = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [D-1:0]    waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [D-1:0]    raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [2**D];
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++) if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_burst_slave_mem.sv
// axi4_burst_slave_mem: single-outstanding AXI4 burst slave over a word RAM; define AXI4_BURST_SLAVE_MEM_RANGE_CHECK_EN for DECERR window checking
module axi4_burst_slave_mem
  import axi4_burst_pkg::*;
#(
  parameter int C_S00_AXI_ID_WIDTH = 1,
  parameter int C_S00_AXI_ADDR_WIDTH = 32,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter logic [C_S00_AXI_ADDR_WIDTH-1:0] C_S00_AXI_BASE_ADDR = 32'h10000000,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input logic s00_axi_aclk,
  input logic s00_axi_aresetn,
  axi4_burst_slave_mem_if.slave s00_axi
);
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int D = C_MEM_DEPTH_LOG2;
  state_t state_q, state_d;
  logic [C_S00_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0] off_q, off_d, ar_off, nxt_off, rd_off;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d, rd_resp;
  logic [DW-1:0] rdata_q, rdata_d, mem_rdata, rd_word;
  logic err_q, err_d, fixed_q, fixed_d, rdy_q, rdy_d, wready_q, wready_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic we, wr_ok, rd_ok, rd_err, aw_err, ar_err, aw_hs, ar_hs, last;
  assign aw_hs = rdy_q & s00_axi.awvalid;
  assign ar_hs = rdy_q & ~s00_axi.awvalid & s00_axi.arvalid;
  assign aw_err = !(s00_axi.awburst inside {BURST_FIXED, BURST_INCR}) || s00_axi.awsize != 3'b010;
  assign ar_err = !(s00_axi.arburst inside {BURST_FIXED, BURST_INCR}) || s00_axi.arsize != 3'b010;
  assign ar_off = s00_axi.araddr - C_S00_AXI_BASE_ADDR;
  assign nxt_off = fixed_q ? off_q : {off_q[AW-1:D+2], off_q[D+1:0] + (D+2)'(4)};
  assign rd_off = state_q == IDLE ? ar_off : nxt_off;
  assign rd_err = state_q == IDLE ? ar_err : err_q;
  assign last = cnt_q == len_q;
`ifdef AXI4_BURST_SLAVE_MEM_RANGE_CHECK_EN
  assign wr_ok = off_q[AW-1:D+2] == '0;
  assign rd_ok = rd_off[AW-1:D+2] == '0;
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif
  assign rd_word = rd_err || !rd_ok ? '0 : mem_rdata;
  assign rd_resp = rd_err ? RESP_SLVERR : rd_ok ? RESP_OKAY : RESP_DECERR;
  axi4_burst_mem_ram #(.DW(DW), .D(D)) u_ram (
    .clk(s00_axi_aclk), .we(we), .be(s00_axi.wstrb), .waddr(off_q[D+1:2]),
    .wdata(s00_axi.wdata), .raddr(rd_off[D+1:2]), .rdata(mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    off_d = off_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fixed_d = fixed_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    rlast_d = rlast_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    we = 1'b0;
    if (aw_hs) begin
      state_d = WDATA;
      id_d = s00_axi.awid;
      off_d = s00_axi.awaddr - C_S00_AXI_BASE_ADDR;
      len_d = s00_axi.awlen;
      cnt_d = '0;
      err_d = aw_err;
      fixed_d = s00_axi.awburst == BURST_FIXED;
      bresp_d = aw_err ? RESP_SLVERR : RESP_OKAY;
    end else if (ar_hs) begin
      state_d = RDATA;
      id_d = s00_axi.arid;
      off_d = ar_off;
      len_d = s00_axi.arlen;
      cnt_d = '0;
      err_d = ar_err;
      fixed_d = s00_axi.arburst == BURST_FIXED;
      rvalid_d = 1'b1;
      rlast_d = s00_axi.arlen == 8'd0;
      rdata_d = rd_word;
      rresp_d = rd_resp;
    end else if (state_q == WDATA && s00_axi.wvalid) begin
      we = ~err_q & wr_ok;
      bresp_d = bresp_q != RESP_OKAY ? bresp_q : s00_axi.wlast != last ? RESP_SLVERR : wr_ok ? RESP_OKAY : RESP_DECERR;
      off_d = nxt_off;
      cnt_d = cnt_q + 8'd1;
      state_d = last ? WRESP : WDATA;
      bvalid_d = last;
    end else if (state_q == WRESP && s00_axi.bready) begin
      state_d = IDLE;
      bvalid_d = 1'b0;
    end else if (state_q == RDATA && s00_axi.rready) begin
      state_d = last ? IDLE : RDATA;
      rvalid_d = ~last;
      if (!last) begin
        off_d = nxt_off;
        cnt_d = cnt_q + 8'd1;
        rlast_d = cnt_q + 8'd1 == len_q;
        rdata_d = rd_word;
        rresp_d = rd_resp;
      end
    end
    rdy_d = state_d == IDLE;
    wready_d = state_d == WDATA;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      id_q <= '0;
      off_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      fixed_q <= 1'b0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdy_q <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      off_q <= off_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fixed_q <= fixed_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      rdy_q <= rdy_d;
      wready_q <= wready_d;
    end
  assign s00_axi.awready = rdy_q;
  assign s00_axi.arready = rdy_q & ~s00_axi.awvalid;
  assign s00_axi.wready = wready_q;
  assign s00_axi.bvalid = bvalid_q;
  assign s00_axi.bresp = bresp_q;
  assign s00_axi.bid = id_q;
  assign s00_axi.rvalid = rvalid_q;
  assign s00_axi.rdata = rdata_q;
  assign s00_axi.rresp = rresp_q;
  assign s00_axi.rlast = rlast_q;
  assign s00_axi.rid = id_q;
endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// tb_axi4_burst_slave_mem: directed self-checking bench for the AXI4 burst slave memory
module tb_axi4_burst_slave_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd_data [256];
  logic [1:0] rd_resp [256];
  logic rd_last [256];
  logic [1:0] b_resp;
  always #5 clk = ~clk;
  axi4_burst_slave_mem_if bus ();
  axi4_burst_slave_mem dut (.s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .s00_axi(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                           input logic [2:0] sz, input logic [31:0] d0, input logic [3:0] st, input logic bad_last);
    int k;
    bus.awid = 1'b1; bus.awaddr = a; bus.awlen = len; bus.awburst = bt; bus.awsize = sz; bus.awvalid = 1'b1;
    k = 0;
    while (!bus.awready && k < 20) begin tick(); k++; end
    if (k >= 20) check("aw_timeout", k, 0);
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = d0 + i; bus.wstrb = st; bus.wlast = (i == int'(len)) ^ bad_last; bus.wvalid = 1'b1;
      k = 0;
      while (!bus.wready && k < 20) begin tick(); k++; end
      if (k >= 20) check("w_timeout", k, 0);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    k = 0;
    while (!bus.bvalid && k < 20) begin tick(); k++; end
    if (k >= 20) check("b_timeout", k, 0);
    b_resp = bus.bresp;
    check("bid", bus.bid, 1);
    tick();
    bus.bready = 1'b0;
  endtask
  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                          input logic [2:0] sz, input int stall);
    int k;
    logic [31:0] held;
    bus.arid = 1'b1; bus.araddr = a; bus.arlen = len; bus.arburst = bt; bus.arsize = sz; bus.arvalid = 1'b1;
    k = 0;
    while (!bus.arready && k < 20) begin tick(); k++; end
    if (k >= 20) check("ar_timeout", k, 0);
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.rready = 1'b1;
      k = 0;
      while (!bus.rvalid && k < 20) begin tick(); k++; end
      if (k >= 20) check("r_timeout", k, 0);
      if (i == stall) begin
        held = bus.rdata;
        bus.rready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_rdata", bus.rdata, held);
          check("stall_rvalid", bus.rvalid, 1);
        end
        bus.rready = 1'b1;
      end
      if (i == 0) check("rid", bus.rid, 1);
      rd_data[i] = bus.rdata; rd_resp[i] = bus.rresp; rd_last[i] = bus.rlast;
      tick();
    end
    bus.rready = 1'b0;
    check("r_done", bus.rvalid, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) tick();
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ids", {bus.bid, bus.rid}, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_awready", bus.awready, 1);
    check("idle_arready", bus.arready, 1);
    axi_write(32'h10000000, 8'd15, 2'b01, 3'b010, 32'd0, 4'hF, 1'b0);
    check("burst_bresp", b_resp, 0);
    axi_read(32'h10000000, 8'd15, 2'b01, 3'b010, -1);
    for (int i = 0; i < 16; i++) begin
      check("burst_rdata", rd_data[i], i);
      check("burst_rlast", rd_last[i], i == 15);
      check("burst_rresp", rd_resp[i], 0);
    end
    axi_read(32'h10000000, 8'd15, 2'b01, 3'b010, 5);
    for (int i = 0; i < 16; i++) check("stall_beat", rd_data[i], i);
    axi_write(32'h10000040, 8'd0, 2'b01, 3'b010, 32'h11223344, 4'hF, 1'b0);
    axi_write(32'h10000040, 8'd0, 2'b01, 3'b010, 32'hAABBCCDD, 4'h3, 1'b0);
    axi_read(32'h10000040, 8'd0, 2'b01, 3'b010, -1);
    check("strb_rdata", rd_data[0], 32'h1122CCDD);
    bus.awid = 1'b1; bus.awaddr = 32'h10000080; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awsize = 3'b010; bus.awvalid = 1'b1;
    bus.arid = 1'b1; bus.araddr = 32'h10000080; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arsize = 3'b010; bus.arvalid = 1'b1;
    #1;
    check("coll_awready", bus.awready, 1);
    check("coll_arready", bus.arready, 0);
    tick();
    bus.awvalid = 1'b0;
    check("coll_ar_wdata", bus.arready, 0);
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("coll_bvalid", bus.bvalid, 1);
    check("coll_ar_wresp", bus.arready, 0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("coll_ar_after_b", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    check("coll_rvalid", bus.rvalid, 1);
    check("coll_rdata", bus.rdata, 32'h55);
    check("coll_rlast", bus.rlast, 1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("coll_r_done", bus.rvalid, 0);
    axi_write(32'h10000040, 8'd1, 2'b10, 3'b010, 32'hFFFFFFFF, 4'hF, 1'b0);
    check("wrap_bresp", b_resp, 2);
    axi_read(32'h10000040, 8'd0, 2'b01, 3'b010, -1);
    check("wrap_unchanged", rd_data[0], 32'h1122CCDD);
    axi_read(32'h10000040, 8'd1, 2'b10, 3'b010, -1);
    check("wrap_rresp0", rd_resp[0], 2);
    check("wrap_rdata0", rd_data[0], 0);
    check("wrap_rresp1", rd_resp[1], 2);
    check("wrap_rlast1", rd_last[1], 1);
    axi_write(32'h10000040, 8'd0, 2'b11, 3'b010, 32'h0, 4'hF, 1'b0);
    check("rsvd_bresp", b_resp, 2);
    axi_write(32'h10000040, 8'd0, 2'b01, 3'b001, 32'h0, 4'hF, 1'b0);
    check("size_bresp", b_resp, 2);
    axi_read(32'h10000040, 8'd0, 2'b01, 3'b000, -1);
    check("size_rresp", rd_resp[0], 2);
    check("size_rdata", rd_data[0], 0);
    axi_write(32'h10000044, 8'd1, 2'b01, 3'b010, 32'h60, 4'hF, 1'b1);
    check("wlast_bresp", b_resp, 2);
    axi_write(32'h10000100, 8'd3, 2'b00, 3'b010, 32'hA0, 4'hF, 1'b0);
    check("fixed_bresp", b_resp, 0);
    axi_read(32'h10000100, 8'd2, 2'b00, 3'b010, -1);
    for (int i = 0; i < 3; i++) check("fixed_rdata", rd_data[i], 32'hA3);
    check("fixed_rlast", rd_last[2], 1);
    axi_write(32'h10000400, 8'd255, 2'b01, 3'b010, 32'h1000, 4'hF, 1'b0);
    check("len255_bresp", b_resp, 0);
    axi_read(32'h10000400, 8'd255, 2'b01, 3'b010, -1);
    for (int i = 0; i < 256; i++) check("len255_rdata", rd_data[i], 32'h1000 + i);
    check("len255_rlast254", rd_last[254], 0);
    check("len255_rlast255", rd_last[255], 1);
    axi_write(32'h10000FFC, 8'd1, 2'b01, 3'b010, 32'h77, 4'hF, 1'b0);
    axi_read(32'h10000000, 8'd0, 2'b01, 3'b010, -1);
    check("winwrap_word0", rd_data[0], 32'h78);
    axi_read(32'h10000FFC, 8'd1, 2'b01, 3'b010, -1);
    check("winwrap_rd0", rd_data[0], 32'h77);
    check("winwrap_rd1", rd_data[1], 32'h78);
    bus.awaddr = 32'h10000200; bus.awlen = 8'd3; bus.awburst = 2'b01; bus.awsize = 3'b010; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1; bus.wdata = 32'h90;
    tick();
    bus.wdata = 32'h91;
    tick();
    rst_n = 1'b0;
    bus.wvalid = 1'b0;
    #1;
    check("midrst_wready", bus.wready, 0);
    check("midrst_bvalid", bus.bvalid, 0);
    check("midrst_awready", bus.awready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_idle", bus.awready, 1);
    check("midrst_nob", bus.bvalid, 0);
    axi_read(32'h10000200, 8'd1, 2'b01, 3'b010, -1);
    check("midrst_word0", rd_data[0], 32'h90);
    check("midrst_word1", rd_data[1], 32'h91);
    axi_write(32'h20000000, 8'd0, 2'b01, 3'b010, 32'hDEADBEEF, 4'hF, 1'b0);
`ifdef AXI4_BURST_SLAVE_MEM_RANGE_CHECK_EN
    check("alias_bresp", b_resp, 3);
    axi_read(32'h10000000, 8'd0, 2'b01, 3'b010, -1);
    check("alias_word0", rd_data[0], 32'h78);
    axi_read(32'h20000000, 8'd0, 2'b01, 3'b010, -1);
    check("alias_rresp", rd_resp[0], 3);
    check("alias_rdata", rd_data[0], 0);
`else
    check("alias_bresp", b_resp, 0);
    axi_read(32'h10000000, 8'd0, 2'b01, 3'b010, -1);
    check("alias_word0", rd_data[0], 32'hDEADBEEF);
    check("alias_rresp", rd_resp[0], 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_burst_slave_mem.md
AXI4_BURST_SLAVE_MEM -- requirements
Module: axi4_burst_slave_mem

Interface
REQ-001 Parameter C_S00_AXI_ID_WIDTH, default 1: width of the AXI ID fields.
REQ-002 Parameter C_S00_AXI_ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter C_S00_AXI_DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-004 Parameter C_S00_AXI_BASE_ADDR, default 32'h10000000: base of the memory window.
REQ-005 Parameter C_MEM_DEPTH_LOG2, default 10: memory depth is 2**C_MEM_DEPTH_LOG2 32-bit words.
REQ-006 s00_axi_aclk  in  1  single clock; all logic is on its rising edge.
REQ-007 s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-008 AW channel: s00_axi_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid are inputs; s00_axi_awready is an output.
REQ-009 W channel: s00_axi_wdata/wstrb[3:0]/wlast/wvalid are inputs; s00_axi_wready is an output.
REQ-010 B channel: s00_axi_bid/bresp[1:0]/bvalid are outputs; s00_axi_bready is an input.
REQ-011 AR channel: s00_axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvalid are inputs; s00_axi_arready is an output.
REQ-012 R channel: s00_axi_rid/rdata/rresp[1:0]/rlast/rvalid are outputs; s00_axi_rready is an input.

Function
REQ-013 The block SHALL be a synthesizable AXI4 burst slave that terminates the master burst stage, with one transaction outstanding at a time.
REQ-014 FSM states SHALL be IDLE, WDATA, WRESP and RDATA.
REQ-015 In IDLE, awready SHALL equal 1; arready SHALL equal !awvalid (write wins when awvalid and arvalid are asserted in the same cycle).
REQ-016 On an AW handshake, the block SHALL capture id, addr, len and burst, clear the beat counter, and go to WDATA.
REQ-017 On an AR handshake, the block SHALL capture id, addr, len and burst, and go to RDATA; the first rvalid is asserted in the next cycle.
REQ-018 In WDATA, wready=1. Each wvalid beat SHALL write the bytes enabled by wstrb to mem[word index], then advance the address by 4 (INCR) or hold it (FIXED).
REQ-019 On the beat where the counter equals len, the block SHALL go to WRESP; if wlast != (counter==len) on any beat, bresp SHALL latch SLVERR (2'b10).
REQ-020 In WRESP, bvalid=1 and bid=captured id; on bready the block SHALL return to IDLE.
REQ-021 In RDATA, rvalid=1, rdata=mem[word index], rid=captured id, rlast=(counter==len).
REQ-022 On rready, the R channel SHALL advance; after the last beat it SHALL return to IDLE.
REQ-023 While rvalid=1 and rready=0, rdata, rlast, rid and rresp SHALL be held stable.
REQ-024 awburst/arburst WRAP (2'b10), reserved (2'b11), or size != 3'b010 SHALL give SLVERR: all beats are still accepted or returned, writes are suppressed, and reads return 0.
REQ-025 Word index SHALL be (addr - C_S00_AXI_BASE_ADDR)[C_MEM_DEPTH_LOG2+1:2]; the address counter wraps modulo the window size.
REQ-026 The beat counter SHALL be 8 bits; len=0 gives one beat and len=255 gives 256 beats.
REQ-027 Throughput SHALL be one beat per cycle when wvalid or rready is held high.

Reset
REQ-028 On reset, all valid/ready outputs, bresp, rresp, rlast, bid, rid and rdata SHALL be 0 and the state SHALL be IDLE.
REQ-029 Reset asserted mid-burst SHALL abort the transaction with no response; words already written SHALL remain, and memory contents are never reset.

Configuration
REQ-030 Macro AXI4_BURST_SLAVE_MEM_RANGE_CHECK_EN, when defined: per beat, an address outside [BASE, BASE+4*2**C_MEM_DEPTH_LOG2) SHALL suppress the write, return rdata 0, and set DECERR (2'b11) for rresp on that beat or for the sticky bresp.
REQ-031 When the macro is undefined, no range check SHALL exist and out-of-window addresses alias per REQ-025.

Structure
REQ-032 A shared package axi4_burst_pkg SHALL hold the resp codes (OKAY/SLVERR/DECERR), the burst codes (FIXED/INCR/WRAP) and the FSM state enum.
REQ-033 The memory array SHALL be sub-module axi4_burst_mem_ram: one write port with byte enables and one asynchronous read port.

Verification
REQ-034 Reset: hold aresetn=0 for 3 cycles -> all outputs 0; awready=1 and arready=1 after release.
REQ-035 Write burst at 0x10000000, len=15, data 0..15, then read the same burst -> bresp=0; rdata 0..15; rlast only on beat 16; rresp=0.
REQ-036 Write 0x11223344 at 0x10000040, then write 0xAABBCCDD with wstrb 4'b0011 -> readback 0x1122CCDD.
REQ-037 awvalid and arvalid rise in the same cycle -> AW handshake first; arready only after the B handshake completes.
REQ-038 rready low for 3 cycles on beat 5 of a 16-beat read -> beat 5 held stable; no beats lost or duplicated.
REQ-039 Write to 0x20000000 -> bresp=DECERR and memory unchanged with the macro; bresp=OKAY with aliasing to word 0 without it.
